// File: rtl/proc_run_ctrl_pkg.sv
// Shared types and constants for the processor run controller.
// The state encoding and the end-address comparison live here so the top
// module and any future helpers use the same definitions.
package proc_run_ctrl_pkg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RSTHOLD = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } run_state_e;

  // PCs are plain byte addresses, so the end test is an unsigned compare.
  function automatic logic pc_reached(input logic [PC_W-1:0] pc,
                                      input logic [PC_W-1:0] end_pc);
    return (pc >= end_pc);
  endfunction

endpackage

// File: rtl/proc_run_ctrl_run_wdog.sv
// run_wdog: RUN-state watchdog counter for proc_run_ctrl.
// Counts enabled cycles after a clear; 'expired' flags the last allowed
// count (WDOG_LIMIT-1), at which point the controller leaves RUN, so the
// counter never has to saturate.
module run_wdog #(
  parameter int unsigned            WDOG_W     = 16,
  parameter logic [WDOG_W-1:0]      WDOG_LIMIT = 16'hFF
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              clear,
  input  logic              en,
  output logic [WDOG_W-1:0] count,
  output logic              expired
);

  localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_LIMIT - WDOG_W'(1);

  logic [WDOG_W-1:0] count_q, count_d;

  // Next count: clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = (count_q == LAST_CNT);

endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: drives the singlecycle core's resetl/startpc to execute one
// program per start request, watches currentpc for the end address, samples
// dmemout after a one-cycle drain and compares it with the expected code.
// A watchdog aborts runs that never reach the end address.
// Optional feature macro: PROC_RUN_CTRL_CYCLE_COUNT_EN (adds the 'cycles'
// register; without it 'cycles' reads as zero).
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int unsigned       RESET_CYCLES = 2,
  parameter int unsigned       WDOG_W       = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT   = 16'hFF
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic [PC_W-1:0]   startpc_in,
  input  logic [PC_W-1:0]   endpc_in,
  input  logic [DATA_W-1:0] expected_in,
  input  logic [PC_W-1:0]   currentpc,
  input  logic [DATA_W-1:0] dmemout,
  output logic              proc_resetl,
  output logic [PC_W-1:0]   proc_startpc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] result,
  output logic [WDOG_W-1:0] cycles
);

  localparam int unsigned     RC_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

  run_state_e        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [PC_W-1:0]   startpc_q, startpc_d;
  logic [PC_W-1:0]   endpc_q, endpc_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              proc_resetl_q, proc_resetl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              wdog_clr;
  logic              wdog_en;
  logic              wdog_expired;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              run_exit;
  logic              cycles_clr;

  // Watchdog only advances in RUN and sits at zero everywhere else, so the
  // first RUN cycle always sees a count of 0.
  run_wdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_run_wdog (
    .CLK     (CLK),
    .resetl  (resetl),
    .clear   (wdog_clr),
    .en      (wdog_en),
    .count   (wdog_cnt),
    .expired (wdog_expired)
  );

  assign wdog_clr = (state_q != RUN);
  assign wdog_en  = (state_q == RUN);

  // Next-state and next-output logic; outputs are decoded from the next
  // state so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    startpc_d   = startpc_q;
    endpc_d     = endpc_q;
    expected_d  = expected_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    result_d    = result_q;
    run_exit    = 1'b0;
    cycles_clr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RSTHOLD;
          startpc_d  = startpc_in;
          endpc_d    = endpc_in;
          expected_d = expected_in;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          result_d   = '0;
          cycles_clr = 1'b1;
          rst_cnt_d  = RC_LOAD;
        end
      end
      RSTHOLD: begin
        if (rst_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end
      RUN: begin
        // End-address match takes priority over a simultaneous timeout.
        if (pc_reached(currentpc, endpc_q)) begin
          state_d  = DRAIN;
          run_exit = 1'b1;
        end else if (wdog_expired) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          run_exit  = 1'b1;
        end
      end
      DRAIN: begin
        // The core has had one extra cycle to settle its final store.
        result_d = dmemout;
        pass_d   = (dmemout == expected_q);
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    proc_resetl_d = (state_d == RUN) || (state_d == DRAIN);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      state_q       <= IDLE;
      rst_cnt_q     <= '0;
      startpc_q     <= '0;
      endpc_q       <= '0;
      expected_q    <= '0;
      proc_resetl_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      startpc_q     <= startpc_d;
      endpc_q       <= endpc_d;
      expected_q    <= expected_d;
      proc_resetl_q <= proc_resetl_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      result_q      <= result_d;
    end
  end

  assign proc_resetl  = proc_resetl_q;
  assign proc_startpc = startpc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign result       = result_q;

`ifdef PROC_RUN_CTRL_CYCLE_COUNT_EN
  logic [WDOG_W-1:0] cycles_q, cycles_d;

  // Capture the RUN length (watchdog count of the exit cycle, plus one).
  always_comb begin
    cycles_d = cycles_q;
    if (cycles_clr) begin
      cycles_d = '0;
    end else if (run_exit) begin
      cycles_d = wdog_cnt + WDOG_W'(1);
    end
  end

  // Sticky run-length register.
  always_ff @(posedge CLK) begin
    if (!resetl) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  logic unused_cycle_sigs;
  assign unused_cycle_sigs = ^{wdog_cnt, run_exit, cycles_clr};
  assign cycles = '0;
`endif

endmodule
